mac_match_ctrl: RTL and testbench
=================================

MAC_MATCH_CTRL -- requirements
Module: mac_match_ctrl

Interface
REQ-001 Parameter HDR_WORDS, default 3: header words per frame presented to the comparator (bytes 0-11: dest and src MAC).
REQ-002 Parameter FLUSH_CYCLES, default 3: zero words fed after the header burst, before the match is sampled.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 n_rst  in  1  reset; asynchronous, active-low.
REQ-005 in_valid / in_sof / in_eof  in  1 each  frame word strobe, first word, last word.
REQ-006 in_data  in  32  frame word; byte 0 in bits [31:24].
REQ-007 in_ready  out  1  word accepted when in_valid && in_ready.
REQ-008 cfg_we  in  1, cfg_mac  in  48  flagged-MAC write from the Atom.
REQ-009 cfg_ready  out  1  cfg_we honoured only when high.
REQ-010 cmp_flagged_mac  out  48, cmp_data  out  32, cmp_clear  out  1  drive mac_comparator.
REQ-011 cmp_match  in  1  registered, sticky match from mac_comparator.
REQ-012 res_valid  out  1, res_ready  in  1  result handshake.
REQ-013 res_hit / res_short  out  1 each  flagged MAC found in header / frame shorter than HDR_WORDS.

Function
REQ-014 FSM states: IDLE, CAPTURE, BURST, FLUSH, SAMPLE, REPORT, SKIP.
REQ-015 IDLE: in_ready=1; word with in_sof -> stored as buffer[0], go CAPTURE; words without in_sof dropped.
REQ-016 CAPTURE: in_ready=1; words stored in order; on word HDR_WORDS-1 -> BURST, recording whether in_eof accompanied it.
REQ-017 in_eof accepted in CAPTURE (or with the sof word) before HDR_WORDS words -> REPORT with res_hit=0, res_short=1; no BURST.
REQ-018 BURST: in_ready=0; buffer[0..HDR_WORDS-1] on cmp_data in consecutive cycles, one per cycle, no gaps; then FLUSH.
REQ-019 FLUSH: in_ready=0; cmp_data=0 for FLUSH_CYCLES cycles; then SAMPLE.
REQ-020 SAMPLE: one cycle; latch res_hit=cmp_match; res_short=0; -> REPORT.
REQ-021 cmp_clear=1 in every state except BURST, FLUSH, SAMPLE; cmp_data=0 outside BURST.
REQ-022 REPORT: in_ready=0; res_valid=1 and res_hit/res_short stable until res_valid && res_ready; then IDLE if frame eof already seen, else SKIP.
REQ-023 SKIP: in_ready=1; words dropped; accepted in_eof -> IDLE; in_sof in SKIP ignored.
REQ-024 Latency, full-length back-to-back frame: res_valid asserts HDR_WORDS+FLUSH_CYCLES+1 cycles after the last header word is accepted.
REQ-025 cfg_ready=1 only in IDLE; cfg_we with cfg_ready loads cmp_flagged_mac next edge; cfg_we otherwise ignored.
REQ-026 cmp_flagged_mac all-zero means disabled: res_hit forced 0 in SAMPLE.
REQ-027 in_sof and in_eof together on the first word in IDLE -> short frame per REQ-017 (when HDR_WORDS>1).

Reset
REQ-028 n_rst low: state IDLE, buffer and counters 0, cmp_flagged_mac 0, res_valid/res_hit/res_short 0, cmp_data 0, cmp_clear 1.
REQ-029 Reset mid-frame abandons the frame; no result is produced for it.

Configuration
REQ-030 Macro MAC_MATCH_STATS_EN defined: adds outputs stat_frames[15:0] (frames reaching REPORT) and stat_hits[15:0] (REPORTs with res_hit=1), each counting on the result handshake, saturating at 0xFFFF, reset to 0.
REQ-031 Macro undefined: those ports and counters are absent; all other behaviour identical.

Structure
REQ-032 Package mac_match_pkg holds the state enum, MAC_W=48, WORD_W=32, and the HDR_WORDS/FLUSH_CYCLES defaults.
REQ-033 Sub-module hdr_word_buffer: HDR_WORDS x 32 register file with write index and read index; the controller owns the FSM and counters.
REQ-034 mac_comparator is instantiated beside this block, not inside it.

Verification (bench models mac_comparator)
REQ-035 cfg_mac=0x00112233_4455; frame words 0x00112233, 0x4455AAAA, 0xBBBBBBBB, eof on word 4 -> res_hit=1, res_short=0; SKIP drops word 4.
REQ-036 Same MAC in source field (words 0xFFFFFFFF, 0xFFFF0011, 0x22334455) -> res_hit=1.
REQ-037 2-word frame with eof on word 1 -> res_short=1, res_hit=0, no BURST cycles.
REQ-038 res_ready held low 10 cycles -> res_valid and res_hit stable; in_ready=0 throughout; cfg_we during this time does not change cmp_flagged_mac.
REQ-039 cfg_mac=0; frame of all-zero words -> res_hit=0.
REQ-040 n_rst pulsed during FLUSH -> IDLE, cmp_clear=1, res_valid never asserts for that frame; next frame processed normally.

Source files
------------

// File: rtl/mac_match_pkg.sv
// Shared types and constants for the flagged-MAC match controller.
package mac_match_pkg;

  localparam int MAC_W            = 48;
  localparam int WORD_W           = 32;
  localparam int HDR_WORDS_DEF    = 3;
  localparam int FLUSH_CYCLES_DEF = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    BURST   = 3'd2,
    FLUSH   = 3'd3,
    SAMPLE  = 3'd4,
    REPORT  = 3'd5,
    SKIP    = 3'd6
  } state_t;

  // Width of an index/counter covering 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_match_ctrl_hdr_word_buffer.sv
// Small register file holding the header words of the current frame.
module hdr_word_buffer
  import mac_match_pkg::*;
#(
  parameter int DEPTH = HDR_WORDS_DEF,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Store one accepted header word at the write index.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mac_match_ctrl.sv
// Flagged-MAC match controller: captures the header of each frame, replays it
// to an external mac_comparator, then reports hit / short-frame status.
// Optional statistics counters are enabled with the macro MAC_MATCH_STATS_EN.
module mac_match_ctrl
  import mac_match_pkg::*;
#(
  parameter int HDR_WORDS    = HDR_WORDS_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cfg_we,
  input  logic [MAC_W-1:0]  cfg_mac,
  output logic              cfg_ready,
  output logic [MAC_W-1:0]  cmp_flagged_mac,
  output logic [WORD_W-1:0] cmp_data,
  output logic              cmp_clear,
  input  logic              cmp_match,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic              res_short
`ifdef MAC_MATCH_STATS_EN
  ,
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_hits
`endif
);

  localparam int IDX_W = idx_width(HDR_WORDS);
  localparam int FC_W  = idx_width(FLUSH_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(HDR_WORDS - 1);
  localparam logic [FC_W-1:0]  LAST_FLUSH = FC_W'(FLUSH_CYCLES - 1);

  state_t state, next_state;

  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  buf_wr_idx;
  logic [FC_W-1:0]   flush_cnt;
  logic              eof_seen;
  logic              in_acc;
  logic              buf_wr_en;
  logic [WORD_W-1:0] buf_rd_data;

  assign in_acc     = in_valid && in_ready;
  assign buf_wr_en  = in_acc && (((state == IDLE) && in_sof) || (state == CAPTURE));
  assign buf_wr_idx = (state == IDLE) ? '0 : wr_idx;

  hdr_word_buffer #(
    .DEPTH (HDR_WORDS),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (buf_wr_en),
    .wr_idx  (buf_wr_idx),
    .wr_data (in_data),
    .rd_idx  (rd_idx),
    .rd_data (buf_rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    cfg_ready  = 1'b0;
    cmp_clear  = 1'b1;
    cmp_data   = '0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
        if (in_acc && in_sof) begin
          if (HDR_WORDS == 1) next_state = BURST;
          else if (in_eof)    next_state = REPORT;
          else                next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        in_ready = 1'b1;
        if (in_acc) begin
          if (wr_idx == LAST_IDX) next_state = BURST;
          else if (in_eof)        next_state = REPORT;
        end
      end
      BURST: begin
        cmp_clear = 1'b0;
        cmp_data  = buf_rd_data;
        if (rd_idx == LAST_IDX) next_state = FLUSH;
      end
      FLUSH: begin
        cmp_clear = 1'b0;
        if (flush_cnt == LAST_FLUSH) next_state = SAMPLE;
      end
      SAMPLE: begin
        cmp_clear  = 1'b0;
        next_state = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) next_state = eof_seen ? IDLE : SKIP;
      end
      SKIP: begin
        in_ready = 1'b1;
        if (in_acc && in_eof) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counters, flagged MAC register and the registered result flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_idx          <= '0;
      rd_idx          <= '0;
      flush_cnt       <= '0;
      eof_seen        <= 1'b0;
      cmp_flagged_mac <= '0;
      res_hit         <= 1'b0;
      res_short       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) cmp_flagged_mac <= cfg_mac;
          if (in_acc && in_sof) begin
            wr_idx    <= IDX_W'(1);
            rd_idx    <= '0;
            eof_seen  <= in_eof;
            res_hit   <= 1'b0;
            res_short <= in_eof && (HDR_WORDS > 1);
          end
        end
        CAPTURE: begin
          if (in_acc) begin
            wr_idx   <= wr_idx + 1'b1;
            eof_seen <= in_eof;
            if (in_eof && (wr_idx != LAST_IDX)) res_short <= 1'b1;
          end
        end
        BURST: begin
          if (rd_idx == LAST_IDX) begin
            rd_idx    <= '0;
            flush_cnt <= '0;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
        FLUSH: flush_cnt <= flush_cnt + 1'b1;
        SAMPLE: begin
          res_hit   <= cmp_match && (cmp_flagged_mac != '0);
          res_short <= 1'b0;
        end
        REPORT: begin
          if (res_ready) begin
            res_hit   <= 1'b0;
            res_short <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAC_MATCH_STATS_EN
  // Saturating frame and hit counters, stepped on each result handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_frames <= '0;
      stat_hits   <= '0;
    end else if (res_valid && res_ready) begin
      if (stat_frames != 16'hFFFF)            stat_frames <= stat_frames + 1'b1;
      if (res_hit && (stat_hits != 16'hFFFF)) stat_hits   <= stat_hits + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_match_ctrl.sv
// Bench for mac_match_ctrl with a behavioural mac_comparator and a result
// scoreboard.
module tb_mac_match_ctrl;
  import mac_match_pkg::*;

  localparam int HW = 3;
  localparam int FC = 3;
  localparam logic [47:0] MAC_A = 48'h0011_2233_4455;

  typedef struct packed {
    logic hit;
    logic is_short;
  } exp_t;

  logic        clk;
  logic        n_rst;
  logic        in_valid, in_sof, in_eof, in_ready;
  logic [31:0] in_data;
  logic        cfg_we, cfg_ready;
  logic [47:0] cfg_mac, cmp_flagged_mac;
  logic [31:0] cmp_data;
  logic        cmp_clear, cmp_match;
  logic        res_valid, res_ready, res_hit, res_short;
`ifdef MAC_MATCH_STATS_EN
  logic [15:0] stat_frames, stat_hits;
`endif

  int   total_checks = 0;
  int   bad_checks   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] burst_q[$];
  int   active_cnt = 0;
  int   lat;
  int   n;
  int   valid_cnt;

  mac_match_ctrl #(
    .HDR_WORDS    (HW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .in_valid        (in_valid),
    .in_sof          (in_sof),
    .in_eof          (in_eof),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .cfg_we          (cfg_we),
    .cfg_mac         (cfg_mac),
    .cfg_ready       (cfg_ready),
    .cmp_flagged_mac (cmp_flagged_mac),
    .cmp_data        (cmp_data),
    .cmp_clear       (cmp_clear),
    .cmp_match       (cmp_match),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_hit         (res_hit),
    .res_short       (res_short)
`ifdef MAC_MATCH_STATS_EN
    ,
    .stat_frames     (stat_frames),
    .stat_hits       (stat_hits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: registered, sticky; looks for the MAC in the dest
  // field (bytes 0-5) or the source field (bytes 6-11) of the streamed header.
  logic [31:0] prev_word;
  logic [63:0] pair;
  int          fed;
  assign pair = {prev_word, cmp_data};
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst || cmp_clear) begin
      prev_word <= '0;
      fed       <= 0;
      cmp_match <= 1'b0;
    end else begin
      prev_word <= cmp_data;
      fed       <= fed + 1;
      if ((fed == 1 && pair[63:16] == cmp_flagged_mac) ||
          (fed == 2 && pair[47:0]  == cmp_flagged_mac))
        cmp_match <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_checks++;
    if (obs !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Present one word and hold it until it is accepted.
  task automatic applyStimulus(input logic [31:0] d, input logic s, input logic e);
    bit accepted;
    int k;
    accepted = 0;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    in_eof   = e;
    while (!accepted && k < 200) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      k++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    in_data  = '0;
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic write_cfg(input logic [47:0] m);
    cfg_we  = 1'b1;
    cfg_mac = m;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic eof_last,
                           input logic hit);
    exp_q.push_back('{hit: hit, is_short: 1'b0});
    active_cnt = 0;
    burst_q.delete();
    applyStimulus(w0, 1'b1, 1'b0);
    applyStimulus(w1, 1'b0, 1'b0);
    applyStimulus(w2, 1'b0, eof_last);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !cfg_ready) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic measure_latency(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!res_valid && cyc < 100);
  endtask

  // Result monitor and comparator-activity recorder.
  always @(negedge clk) begin
    if (n_rst && !cmp_clear) begin
      active_cnt++;
      burst_q.push_back(cmp_data);
    end
    if (n_rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("res_hit", res_hit, mon_e.hit);
        checkOutput("res_short", res_short, mon_e.is_short);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_eof    = 1'b0;
    in_data   = '0;
    cfg_we    = 1'b0;
    cfg_mac   = '0;
    res_ready = 1'b1;
    #3;
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_hit", res_hit, 0);
    checkOutput("rst_res_short", res_short, 0);
    checkOutput("rst_cmp_data", cmp_data, 0);
    checkOutput("rst_cmp_clear", cmp_clear, 1);
    checkOutput("rst_mac", cmp_flagged_mac, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Dest-field match, eof on a fourth word dropped in SKIP.
    write_cfg(MAC_A);
    checkOutput("cfg_load", cmp_flagged_mac, MAC_A);
    run_frame(32'h0011_2233, 32'h4455_AAAA, 32'hBBBB_BBBB, 1'b0, 1'b1);
    fork
      applyStimulus(32'hCCCC_CCCC, 1'b0, 1'b1);
      measure_latency(lat);
    join
    checkOutput("latency", lat, HW + FC + 1);
    wait_done("t1");
    checkOutput("idle_after_skip", cfg_ready, 1);
    checkOutput("active_cycles", active_cnt, HW + FC + 1);
    checkOutput("burst_len", burst_q.size(), HW + FC + 1);
    if (burst_q.size() >= HW + FC + 1) begin
      checkOutput("burst_w0", burst_q[0], 32'h0011_2233);
      checkOutput("burst_w1", burst_q[1], 32'h4455_AAAA);
      checkOutput("burst_w2", burst_q[2], 32'hBBBB_BBBB);
      for (int i = HW; i < HW + FC + 1; i++) checkOutput("flush_zero", burst_q[i], 0);
    end

    // Source-field match, eof on last header word.
    run_frame(32'hFFFF_FFFF, 32'hFFFF_0011, 32'h2233_4455, 1'b1, 1'b1);
    wait_done("t2");

    // No match anywhere.
    run_frame(32'h1234_5678, 32'h9ABC_DEF0, 32'h0011_2233, 1'b1, 1'b0);
    wait_done("t3");

    // Two-word short frame.
    exp_q.push_back('{hit: 1'b0, is_short: 1'b1});
    active_cnt = 0;
    applyStimulus(32'h0011_2233, 1'b1, 1'b0);
    applyStimulus(32'h4455_0000, 1'b0, 1'b1);
    wait_done("t4");
    checkOutput("short_no_burst", active_cnt, 0);

    // sof and eof on the same word.
    exp_q.push_back('{hit: 1'b0, is_short: 1'b1});
    active_cnt = 0;
    applyStimulus(32'h0011_2233, 1'b1, 1'b1);
    wait_done("t5");
    checkOutput("sofeof_no_burst", active_cnt, 0);

    // Back-pressured result, config writes ignored meanwhile.
    res_ready = 1'b0;
    run_frame(32'h0011_2233, 32'h4455_AAAA, 32'hBBBB_BBBB, 1'b1, 1'b1);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bp_valid_seen", res_valid, 1);
    cfg_we  = 1'b1;
    cfg_mac = 48'hDEAD_BEEF_0001;
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_valid", res_valid, 1);
      checkOutput("bp_hit", res_hit, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_mac", cmp_flagged_mac, MAC_A);
    end
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
    res_ready = 1'b1;
    wait_done("t6");
    checkOutput("bp_mac_after", cmp_flagged_mac, MAC_A);

    // Disabled MAC never hits, even though an all-zero frame matches it.
    write_cfg(48'h0);
    checkOutput("cfg_zero", cmp_flagged_mac, 0);
    run_frame(32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    wait_done("t7");

    // Reset during FLUSH abandons the frame.
    write_cfg(MAC_A);
    applyStimulus(32'h0011_2233, 1'b1, 1'b0);
    applyStimulus(32'h4455_AAAA, 1'b0, 1'b0);
    applyStimulus(32'hBBBB_BBBB, 1'b0, 1'b0);
    repeat (HW + 1) @(posedge clk);
    #1;
    checkOutput("in_flush_clear", cmp_clear, 0);
    checkOutput("in_flush_data", cmp_data, 0);
    n_rst = 1'b0;
    #1;
    checkOutput("mid_rst_clear", cmp_clear, 1);
    checkOutput("mid_rst_idle", cfg_ready, 1);
    checkOutput("mid_rst_valid", res_valid, 0);
    checkOutput("mid_rst_mac", cmp_flagged_mac, 0);
    @(negedge clk);
    n_rst = 1'b1;
    valid_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) valid_cnt++;
    end
    checkOutput("abandoned_no_result", valid_cnt, 0);
    @(posedge clk);
    #1;
    write_cfg(MAC_A);
    run_frame(32'h0011_2233, 32'h4455_AAAA, 32'hBBBB_BBBB, 1'b1, 1'b1);
    wait_done("t8");

`ifdef MAC_MATCH_STATS_EN
    checkOutput("stat_frames", stat_frames, 1);
    checkOutput("stat_hits", stat_hits, 1);
`endif

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
